// File: rtl/rhs2116_acq_scheduler.sv
// RHS2116 acquisition scheduler: a periodic tick launches a sweep of CONVERT
// transactions over the enabled channels, one SPI transfer and one frame in flight.
module rhs2116_acq_scheduler #(
  parameter int NUM_CH   = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                spi_start,
  output logic [15:0]         spi_cmd,
  input  logic                spi_busy,
  input  logic                spi_done,
  input  logic [31:0]         spi_rdata,
  output logic [31:0]         frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [7:0]          sweep_cnt,
  output logic [7:0]          overrun_cnt,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, WAIT_DONE, PUSH} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [NUM_CH-1:0]   mask_q;
  logic [3:0]          ch;
  logic                tick;
  logic                first_vld, next_vld;
  logic [3:0]          first_ch, next_ch;
  logic                unused_rdata;

  assign tick         = enable && (cnt == period);
  assign busy         = (state != IDLE) && (state != WAIT_TICK);
  assign unused_rdata = ^spi_rdata[31:28];

  // Lowest set bit of the live mask starts a sweep; the next set bit above ch
  // in the latched mask continues it.
  always_comb begin
    first_vld = 1'b0;
    first_ch  = '0;
    next_vld  = 1'b0;
    next_ch   = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_vld = 1'b1;
        first_ch  = 4'(i);
      end
      if (mask_q[i] && (i > int'(ch))) begin
        next_vld = 1'b1;
        next_ch  = 4'(i);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mask_q      <= '0;
      ch          <= '0;
      spi_start   <= 1'b0;
      spi_cmd     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      sweep_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      spi_start <= 1'b0;

      if (!enable || tick) cnt <= '0;
      else                 cnt <= cnt + PERIOD_W'(1);

      if (tick && busy && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: if (enable) state <= WAIT_TICK;

        WAIT_TICK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick && first_vld) begin
            mask_q  <= ch_mask;
            ch      <= first_ch;
            spi_cmd <= {4'b0000, first_ch, 8'h00};
            // Launch straight from the tick so the request lands one cycle later.
            if (!spi_busy) begin
              spi_start <= 1'b1;
              state     <= WAIT_DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (!spi_busy) begin
            spi_start <= 1'b1;
            state     <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (spi_done) begin
            frame_data  <= {ch, spi_rdata[27:0]};
            frame_valid <= 1'b1;
            state       <= PUSH;
          end
        end

        PUSH: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (next_vld && enable) begin
              ch      <= next_ch;
              spi_cmd <= {4'b0000, next_ch, 8'h00};
              state   <= ISSUE;
            end else begin
              // A sweep only counts when every latched channel was delivered.
              if (!next_vld) sweep_cnt <= sweep_cnt + 8'd1;
              state <= enable ? WAIT_TICK : IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rhs2116_acq_scheduler.sv
// Directed bench for rhs2116_acq_scheduler with a fixed-latency SPI master model.
module tb_rhs2116_acq_scheduler;

  logic        clk_sys = 1'b0;
  logic        rst, enable, frame_ready;
  logic [15:0] period, ch_mask;
  logic        spi_start;
  logic [15:0] spi_cmd;
  logic        spi_busy  = 1'b0;
  logic        spi_done  = 1'b0;
  logic [31:0] spi_rdata = 32'h0;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic [7:0]  sweep_cnt, overrun_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 4;
  int sc    = 0;
  logic [15:0] cmd_q[$];
  int          st_q[$];
  logic [31:0] frm_q[$];

  always #5 clk_sys = ~clk_sys;

  rhs2116_acq_scheduler #(.NUM_CH(16), .PERIOD_W(16)) dut (
    .clk_sys(clk_sys), .rst(rst), .enable(enable), .period(period), .ch_mask(ch_mask),
    .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_rdata(spi_rdata), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .sweep_cnt(sweep_cnt), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  // SPI master: done pulses lat cycles after the start is seen; ignores design reset.
  always @(posedge clk_sys) begin
    spi_done <= 1'b0;
    if (spi_start === 1'b1) begin
      spi_busy <= 1'b1;
      sc       <= lat;
    end else if (spi_busy) begin
      if (sc == 1) begin
        spi_busy  <= 1'b0;
        spi_done  <= 1'b1;
        spi_rdata <= 32'hA000_0123;
      end
      sc <= sc - 1;
    end
  end

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (spi_start === 1'b1) begin
      cmd_q.push_back(spi_cmd);
      st_q.push_back(cyc);
    end
    if (frame_valid === 1'b1 && frame_ready === 1'b1) frm_q.push_back(frame_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sweep(input logic [7:0] n, input int budget, input string tag);
    int k = 0;
    while (sweep_cnt !== n && k < budget) begin @(negedge clk_sys); k++; end
    chk(tag, 32'(sweep_cnt), 32'(n));
  endtask

  task automatic wait_nstart(input int n, input int budget, input string tag);
    int k = 0;
    while (st_q.size() < n && k < budget) begin @(negedge clk_sys); k++; end
    chk(tag, st_q.size(), n);
  endtask

  task automatic wait_nfrm(input int n, input int budget, input string tag);
    int k = 0;
    while (frm_q.size() < n && k < budget) begin @(negedge clk_sys); k++; end
    chk(tag, frm_q.size(), n);
  endtask

  task automatic wait_fv(input int budget, input string tag);
    int k = 0;
    while (frame_valid !== 1'b1 && k < budget) begin @(negedge clk_sys); k++; end
    chk(tag, 32'(frame_valid), 32'd1);
  endtask

  initial begin
    int c0, sb, fb, bad;
    logic [31:0] fd;
    logic fv_seen;

    rst = 1'b1; enable = 1'b0; period = 16'd999; ch_mask = 16'h0; frame_ready = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_cmd", 32'(spi_cmd), 32'd0);
    chk("rst_fdata", frame_data, 32'd0);
    chk("rst_fvalid", 32'(frame_valid), 32'd0);
    chk("rst_sweep", 32'(sweep_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic sweep, mask 0x0005, ticks every 1000 cycles
    c0 = cyc; rst = 1'b0; enable = 1'b1; ch_mask = 16'h0005;
    wait_sweep(8'd2, 2500, "basic_sweeps");
    chk("basic_nstart", st_q.size(), 4);
    chk("basic_cmd0", 32'(cmd_q[0]), 32'h0000);
    chk("basic_cmd1", 32'(cmd_q[1]), 32'h0200);
    chk("basic_cmd2", 32'(cmd_q[2]), 32'h0000);
    chk("basic_cmd3", 32'(cmd_q[3]), 32'h0200);
    chk("basic_nfrm", frm_q.size(), 4);
    chk("basic_frm0", frm_q[0], 32'h0000_0123);
    chk("basic_frm1", frm_q[1], 32'h2000_0123);
    chk("basic_frm3", frm_q[3], 32'h2000_0123);
    chk("basic_first_lat", st_q[0], c0 + 1000);
    chk("basic_tick_gap", st_q[2] - st_q[0], 1000);
    chk("basic_ch_gap", st_q[1] - st_q[0], 8);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_ovr", 32'(overrun_cnt), 32'd0);

    // Backpressure on the ch0 frame
    frame_ready = 1'b0;
    wait_fv(1500, "bp_fv_rise");
    fd = frame_data; sb = st_q.size(); bad = 0;
    repeat (50) begin
      @(negedge clk_sys);
      if (frame_valid !== 1'b1 || frame_data !== fd) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_data", fd, 32'h0000_0123);
    chk("bp_nostart", st_q.size(), sb);
    chk("bp_busy", 32'(busy), 32'd1);
    frame_ready = 1'b1;
    @(negedge clk_sys);
    chk("bp_fv_drop", 32'(frame_valid), 32'd0);
    chk("bp_no_early_start", 32'(spi_start), 32'd0);
    @(negedge clk_sys);
    chk("bp_start", 32'(spi_start), 32'd1);
    chk("bp_cmd", 32'(spi_cmd), 32'h0200);
    wait_sweep(8'd3, 200, "bp_sweep");
    chk("bp_frm_ch0", frm_q[4], 32'h0000_0123);
    chk("bp_frm_ch2", frm_q[5], 32'h2000_0123);

    // Empty mask: ticks are ignored
    rst = 1'b1; enable = 1'b0;
    @(negedge clk_sys);
    rst = 1'b0; period = 16'd9; ch_mask = 16'h0; enable = 1'b1; sb = st_q.size();
    repeat (120) @(negedge clk_sys);
    chk("empty_nostart", st_q.size(), sb);
    chk("empty_sweep", 32'(sweep_cnt), 32'd0);
    chk("empty_ovr", 32'(overrun_cnt), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);

    // Mask change after the ch1 frame only affects the next sweep
    fb = frm_q.size(); period = 16'd999; ch_mask = 16'h000F;
    wait_nfrm(fb + 2, 1200, "mc_ch1_frame");
    ch_mask = 16'h0001;
    wait_sweep(8'd1, 200, "mc_sweep1");
    wait_sweep(8'd2, 1200, "mc_sweep2");
    chk("mc_nfrm", frm_q.size(), fb + 5);
    chk("mc_nstart", st_q.size(), sb + 5);
    chk("mc_frm2", frm_q[fb + 2], 32'h2000_0123);
    chk("mc_frm3", frm_q[fb + 3], 32'h3000_0123);
    chk("mc_frm4", frm_q[fb + 4], 32'h0000_0123);

    // enable drop while waiting on ch1
    lat = 30; ch_mask = 16'h000F; sb = st_q.size(); fb = frm_q.size();
    wait_nstart(sb + 2, 1200, "en_ch1_start");
    enable = 1'b0;
    repeat (80) @(negedge clk_sys);
    chk("en_nstart", st_q.size(), sb + 2);
    chk("en_nfrm", frm_q.size(), fb + 2);
    chk("en_last_frm", frm_q[fb + 1], 32'h1000_0123);
    chk("en_sweep", 32'(sweep_cnt), 32'd2);
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_fvalid", 32'(frame_valid), 32'd0);

    // Overrun: 44-cycle channels, 16 per sweep, ticks every 21 -> 33 per sweep
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0; period = 16'd20; ch_mask = 16'hFFFF; lat = 40; enable = 1'b1; sb = st_q.size();
    wait_sweep(8'd1, 1000, "ovr_sweep1");
    chk("ovr_first", 32'(overrun_cnt), 32'd33);
    wait_sweep(8'd7, 5000, "ovr_sweep7");
    chk("ovr_seven", 32'(overrun_cnt), 32'd231);
    wait_sweep(8'd8, 1000, "ovr_sweep8");
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (cmd_q[sb + i] !== {4'h0, 4'(i % 16), 8'h00}) bad++;
    chk("ovr_order", bad, 0);

    // Reset mid-transaction, late spi_done must be ignored
    sb = st_q.size();
    wait_nstart(sb + 1, 100, "rs_start");
    rst = 1'b1; enable = 1'b0;
    @(negedge clk_sys);
    rst = 1'b0;
    chk("rs_start", 32'(spi_start), 32'd0);
    chk("rs_cmd", 32'(spi_cmd), 32'd0);
    chk("rs_fdata", frame_data, 32'd0);
    chk("rs_fvalid", 32'(frame_valid), 32'd0);
    chk("rs_sweep", 32'(sweep_cnt), 32'd0);
    chk("rs_ovr", 32'(overrun_cnt), 32'd0);
    fv_seen = 1'b0;
    repeat (60) begin
      @(negedge clk_sys);
      if (frame_valid !== 1'b0) fv_seen = 1'b1;
    end
    chk("rs_no_fv", 32'(fv_seen), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_fdata_after", frame_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
